// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program-counter unit with sequential advance, jump/branch
// redirects and a one-entry buffer for a redirect that arrives while fetch
// is blocked.
// Optional feature macro: PC_TRAP_EN (adds trap_i, epc_o and TRAP_VECTOR).
//
// state  | meaning
// S_BOOT | leaving reset, no fetch request issued yet
// S_RUN  | issuing fetches, no redirect buffered
// S_HOLD | fetch blocked with a redirect target buffered in r_pend_pc
module pc_fetch_unit #(
  parameter int               XLEN         = 32,
  parameter int               INC          = 4,
  parameter logic [XLEN-1:0]  RESET_VECTOR = '0
`ifdef PC_TRAP_EN
  ,parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100)
`endif
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_i,
  input  logic            jump_i,
  input  logic [XLEN-1:0] jump_target_i,
  input  logic            branch_taken_i,
  input  logic [XLEN-1:0] branch_target_i,
  input  logic            imem_ready_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus4_o,
  output logic            pc_valid_o,
  output logic            misalign_o
`ifdef PC_TRAP_EN
  ,input  logic            trap_i,
  output logic [XLEN-1:0] epc_o
`endif
);

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_HOLD} state_t;

  state_t          r_state, w_state_nxt;
  logic [XLEN-1:0] r_pc, w_pc_nxt;
  logic [XLEN-1:0] r_pend_pc, w_pend_nxt;
  logic            r_misalign, w_misalign_nxt;
  logic            w_adv;
  logic            w_redir;
  logic [XLEN-1:0] w_redir_raw;
  logic [XLEN-1:0] w_redir_tgt;
  logic            w_redir_mis;
  logic [XLEN-1:0] w_pc_inc;
`ifdef PC_TRAP_EN
  logic [XLEN-1:0] r_epc, w_epc_nxt;
`endif

  // Redirect selection: jump beats branch; the low two bits are dropped so
  // the PC always stays word aligned, and the drop is reported as misalign.
  assign w_redir     = jump_i | branch_taken_i;
  assign w_redir_raw = jump_i ? jump_target_i : branch_target_i;
  assign w_redir_tgt = {w_redir_raw[XLEN-1:2], 2'b00};
  assign w_redir_mis = w_redir & (|w_redir_raw[1:0]);
  assign w_pc_inc    = r_pc + XLEN'(INC);

  assign pc_valid_o  = (r_state != S_BOOT);
  assign w_adv       = pc_valid_o & imem_ready_i & ~stall_i;
  assign pc_o        = r_pc;
  assign pc_plus4_o  = w_pc_inc;
  assign misalign_o  = r_misalign;
`ifdef PC_TRAP_EN
  assign epc_o       = r_epc;
`endif

  // Next-state, next-PC and pending-buffer decisions.
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_pend_nxt     = r_pend_pc;
    w_misalign_nxt = 1'b0;
`ifdef PC_TRAP_EN
    w_epc_nxt      = r_epc;
`endif
    case (r_state)
      S_BOOT: w_state_nxt = S_RUN;
      S_RUN: begin
        if (w_adv) begin
          w_pc_nxt       = w_redir ? w_redir_tgt : w_pc_inc;
          w_misalign_nxt = w_redir_mis;
        end else if (w_redir) begin
          w_pend_nxt     = w_redir_tgt;
          w_state_nxt    = S_HOLD;
          w_misalign_nxt = w_redir_mis;
        end
      end
      S_HOLD: begin
        if (w_adv) begin
          // A fresh redirect in the releasing cycle is newer than the buffer.
          w_pc_nxt       = w_redir ? w_redir_tgt : r_pend_pc;
          w_pend_nxt     = '0;
          w_state_nxt    = S_RUN;
          w_misalign_nxt = w_redir_mis;
        end else if (w_redir) begin
          w_pend_nxt     = w_redir_tgt;
          w_misalign_nxt = w_redir_mis;
        end
      end
      default: w_state_nxt = S_BOOT;
    endcase
`ifdef PC_TRAP_EN
    // Trap overrides everything, including stall and imem backpressure.
    if (trap_i) begin
      w_epc_nxt      = r_pc;
      w_pc_nxt       = TRAP_VECTOR;
      w_pend_nxt     = '0;
      w_state_nxt    = S_RUN;
      w_misalign_nxt = 1'b0;
    end
`endif
  end

  // State, PC, pending buffer and misalign pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_BOOT;
      r_pc       <= RESET_VECTOR;
      r_pend_pc  <= '0;
      r_misalign <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_pend_pc  <= w_pend_nxt;
      r_misalign <= w_misalign_nxt;
    end
  end

`ifdef PC_TRAP_EN
  // Exception PC captured on trap entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_epc <= '0;
    else        r_epc <= w_epc_nxt;
  end
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: each driven cycle pushes the expected post-edge
// PC/valid/misalign to a scoreboard queue, popped and compared after the edge.
module tb_pc_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        stall_i;
  logic        jump_i;
  logic [31:0] jump_target_i;
  logic        branch_taken_i;
  logic [31:0] branch_target_i;
  logic        imem_ready_i;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic        pc_valid_o;
  logic        misalign_o;
`ifdef PC_TRAP_EN
  logic        trap_i;
  logic [31:0] epc_o;
`endif

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic        vld;
    logic        mis;
    logic        chk_mis;
  } exp_t;

  exp_t sb_q[$];

  pc_fetch_unit dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall_i         (stall_i),
    .jump_i          (jump_i),
    .jump_target_i   (jump_target_i),
    .branch_taken_i  (branch_taken_i),
    .branch_target_i (branch_target_i),
    .imem_ready_i    (imem_ready_i),
    .pc_o            (pc_o),
    .pc_plus4_o      (pc_plus4_o),
    .pc_valid_o      (pc_valid_o),
    .misalign_o      (misalign_o)
`ifdef PC_TRAP_EN
    ,.trap_i         (trap_i),
    .epc_o           (epc_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle at the falling edge, push expectation, compare after the rising edge.
  task automatic step(input string tag, input logic rdy, input logic st,
                      input logic jmp, input logic [31:0] jt,
                      input logic br, input logic [31:0] bt,
                      input logic [31:0] e_pc, input logic e_vld,
                      input logic e_mis, input logic e_chk_mis);
    exp_t e;
    imem_ready_i    = rdy;
    stall_i         = st;
    jump_i          = jmp;
    jump_target_i   = jt;
    branch_taken_i  = br;
    branch_target_i = bt;
    e.tag = tag; e.pc = e_pc; e.vld = e_vld; e.mis = e_mis; e.chk_mis = e_chk_mis;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    chk({tag, "_qdepth"}, 32'(sb_q.size()), 32'd1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk({e.tag, "_pc"}, pc_o, e.pc);
      chk({e.tag, "_vld"}, {31'd0, pc_valid_o}, {31'd0, e.vld});
      if (e.chk_mis) chk({e.tag, "_mis"}, {31'd0, misalign_o}, {31'd0, e.mis});
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    stall_i = 1'b0; jump_i = 1'b0; jump_target_i = '0;
    branch_taken_i = 1'b0; branch_target_i = '0; imem_ready_i = 1'b1;
`ifdef PC_TRAP_EN
    trap_i = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_pc", pc_o, 32'h0);
    chk("rst_vld", {31'd0, pc_valid_o}, 32'd0);
    chk("rst_mis", {31'd0, misalign_o}, 32'd0);
    chk("rst_plus4", pc_plus4_o, 32'h4);
`ifdef PC_TRAP_EN
    chk("rst_epc", epc_o, 32'h0);
`endif
    rst_n = 1'b1;

    // T1: boot then sequential
    step("boot",  1, 0, 0, 0, 0, 0, 32'h0, 1, 0, 1);
    step("seq4",  1, 0, 0, 0, 0, 0, 32'h4, 1, 0, 1);
    step("seq8",  1, 0, 0, 0, 0, 0, 32'h8, 1, 0, 1);
    // T2: stall holds
    for (int i = 0; i < 3; i++)
      step("stall", 1, 1, 0, 0, 0, 0, 32'h8, 1, 0, 1);
    step("unstall", 1, 0, 0, 0, 0, 0, 32'hC, 1, 0, 1);
    // T3: priority
    step("jmp_br", 1, 0, 1, 32'h200, 1, 32'h300, 32'h200, 1, 0, 1);
    step("br",     1, 0, 0, 0,       1, 32'h300, 32'h300, 1, 0, 1);
    step("seq304", 1, 0, 0, 0,       0, 0,       32'h304, 1, 0, 1);
    // T4: buffered redirect, newest wins
    step("hold_br",  0, 0, 0, 0,      1, 32'h40, 32'h304, 1, 0, 1);
    step("hold_jmp", 0, 0, 1, 32'h80, 0, 0,      32'h304, 1, 0, 1);
    step("release",  1, 0, 0, 0,      0, 0,      32'h80,  1, 0, 1);
    step("seq84",    1, 0, 0, 0,      0, 0,      32'h84,  1, 0, 1);
    // stall with ready still buffers the redirect
    step("stall_jmp", 1, 1, 1, 32'h600, 0, 0, 32'h84,  1, 0, 1);
    step("stall_rel", 1, 0, 0, 0,       0, 0, 32'h600, 1, 0, 1);
    // T5: misalign and wrap
    step("mis_br",   1, 0, 0, 0, 1, 32'h103, 32'h100, 1, 1, 1);
    step("mis_end",  1, 0, 0, 0, 0, 0,       32'h104, 1, 0, 1);
    step("jmp_top",  1, 0, 1, 32'hFFFF_FFFC, 0, 0, 32'hFFFF_FFFC, 1, 0, 1);
    chk("wrap_plus4", pc_plus4_o, 32'h0);
    step("wrap",     1, 0, 0, 0, 0, 0, 32'h0, 1, 0, 1);
    step("mis_cap",  0, 0, 1, 32'h55, 0, 0, 32'h0,  1, 1, 1);
    step("mis_take", 1, 0, 0, 0,      0, 0, 32'h54, 1, 0, 0);
    step("seq58",    1, 0, 0, 0,      0, 0, 32'h58, 1, 0, 1);
`ifdef PC_TRAP_EN
    // T6: trap during stall with a buffered redirect
    step("to44",    1, 0, 1, 32'h44, 0, 0, 32'h44, 1, 0, 1);
    step("t_hold",  1, 1, 0, 0, 1, 32'h300, 32'h44, 1, 0, 1);
    trap_i = 1'b1;
    step("trap",    1, 1, 0, 0, 0, 0, 32'h100, 1, 0, 1);
    trap_i = 1'b0;
    chk("trap_epc", epc_o, 32'h44);
    step("t_after", 1, 0, 0, 0, 0, 0, 32'h104, 1, 0, 1);
    step("to58",    1, 0, 1, 32'h58, 0, 0, 32'h58, 1, 0, 1);
`endif
    // Reset while in HOLD discards the pending target immediately
    step("pre_rst", 0, 0, 0, 0, 1, 32'h500, 32'h58, 1, 0, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_pc", pc_o, 32'h0);
    chk("mid_rst_vld", {31'd0, pc_valid_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step("reboot", 1, 0, 0, 0, 0, 0, 32'h0, 1, 0, 1);
    step("no_pend", 1, 0, 0, 0, 0, 0, 32'h4, 1, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
